// File: rtl/dds_cfg_axis.sv
// Purpose : forwards sweep-controller phase words (pinc/poff) to a DDS AXI-Stream
//           config port. A single-entry pending slot absorbs strobes while the DDS stalls.
// Latency : strobe in IDLE at cycle N -> tvalid at N+1; back-to-back words with no bubble.
// Backpressure: tdata held while tready=0. Newer strobes overwrite the pending slot (o_coalesced).
// Ports   : clk/rst (sync, active-high); i_pinc/i_poff/i_cfg_valid/i_running from the sweep
//           controller; m_axis_config_* to the DDS; o_busy/o_coalesced/o_timeout/o_sent_cnt status.
// Option  : `define DDS_CFG_RESYNC_EN to flag the first word after an i_running rise (tdata[32]).
module dds_cfg_axis #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      i_pinc,
  input  logic [15:0]      i_poff,
  input  logic             i_cfg_valid,
  input  logic             i_running,
  output logic [39:0]      m_axis_config_tdata,
  output logic             m_axis_config_tvalid,
  input  logic             m_axis_config_tready,
  output logic             o_busy,
  output logic             o_coalesced,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_sent_cnt
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Counter just wide enough to hold TIMEOUT_CYCLES; it saturates there.
  localparam int STALL_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYCLES);

  state_t             state_q, state_d;
  logic [39:0]        tdata_q, tdata_d;
  logic               pend_q, pend_d;
  logic [31:0]        pend_dat_q, pend_dat_d;
  logic               coal_q, coal_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               hs;
  logic               new_rs;     // resync bit for a word captured from the inputs this cycle
  logic               pend_rs_q;  // resync bit travelling with the pending word
  logic [39:0]        new_word;

  assign hs       = (state_q == SEND) && m_axis_config_tready;
  assign new_word = {7'b0, new_rs, i_poff, i_pinc};

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. Only a handshake with nothing left to send returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (i_cfg_valid) state_d = SEND;
    end else begin
      if (hs && !i_cfg_valid && !pend_q) state_d = IDLE;
    end
  end

  // FSM: outputs
  always_comb begin
    m_axis_config_tvalid = (state_q == SEND);
  end

  // Datapath, counters and watchdog
  always_comb begin
    tdata_d    = tdata_q;
    pend_d     = pend_q;
    pend_dat_d = pend_dat_q;
    coal_d     = 1'b0;
    cnt_d      = cnt_q;
    if (state_q == IDLE) begin
      if (i_cfg_valid) tdata_d = new_word;
    end else if (hs) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (i_cfg_valid) begin
        // The fresh strobe wins over the older pending word.
        tdata_d = new_word;
        pend_d  = 1'b0;
        coal_d  = pend_q;
      end else if (pend_q) begin
        tdata_d = {7'b0, pend_rs_q, pend_dat_q};
        pend_d  = 1'b0;
      end
    end else if (i_cfg_valid) begin
      // Stalled: tdata must not move, so park the word in the pending slot.
      pend_dat_d = {i_poff, i_pinc};
      pend_d     = 1'b1;
      coal_d     = pend_q;
    end

    stall_d = '0;
    if ((state_q == SEND) && !hs)
      stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + STALL_W'(1);
    timeout_d = timeout_q | ((TIMEOUT_CYCLES != 0) && (stall_d == STALL_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tdata_q    <= '0;
      pend_q     <= 1'b0;
      pend_dat_q <= '0;
      coal_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
      stall_q    <= '0;
    end else begin
      tdata_q    <= tdata_d;
      pend_q     <= pend_d;
      pend_dat_q <= pend_dat_d;
      coal_q     <= coal_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
      stall_q    <= stall_d;
    end
  end

`ifdef DDS_CFG_RESYNC_EN
  logic running_q, resync_req_q, resync_req_d, pend_rs_d, rise;

  // A rise coinciding with a capture goes straight into the word; any capture
  // consumes the request. A coalesced/replaced pending word keeps its flag so
  // the resync is never lost.
  always_comb begin
    rise         = i_running & ~running_q;
    new_rs       = resync_req_q | rise | (pend_q & pend_rs_q);
    resync_req_d = i_cfg_valid ? 1'b0 : (resync_req_q | rise);
    pend_rs_d    = ((state_q == SEND) && !hs && i_cfg_valid) ? new_rs : pend_rs_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running_q    <= 1'b0;
      resync_req_q <= 1'b0;
      pend_rs_q    <= 1'b0;
    end else begin
      running_q    <= i_running;
      resync_req_q <= resync_req_d;
      pend_rs_q    <= pend_rs_d;
    end
  end
`else
  logic unused_running;
  assign unused_running = i_running;
  assign new_rs         = 1'b0;
  assign pend_rs_q      = 1'b0;
`endif

  assign m_axis_config_tdata = tdata_q;
  assign o_busy              = m_axis_config_tvalid | pend_q;
  assign o_coalesced         = coal_q;
  assign o_timeout           = timeout_q;
  assign o_sent_cnt          = cnt_q;

endmodule
